fetch_pc_unit: RTL

Instruction-fetch next-PC stage directly upstream of the 2-bit branch predictor. Holds the fetch PC and drives it to the predictor's `pc` input. Contains a direct-mapped branch target buffer (BTB) and combines a BTB hit with the predictor's `predict_taken` to steer fetch. Takes branch resolution from EX, then:
- redirects fetch on a mispredict;
- generates the predictor's `update_en` / `actual_taken`;
- trains the BTB.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/btb_direct_mapped.sv | 73 +++++++
 rtl/fetch_pc_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and BTB address helpers for the fetch next-PC stage
//
// Purpose: instruction size, the BTB entry layout and the index/tag extraction
// functions used by fetch_pc_unit and btb_direct_mapped.
// Ports: none (package).
// Entry fields are held at MAX_PC_W and zero-extended so one struct serves
// any PC_WIDTH / BTB_ENTRIES combination up to 64-bit PCs.

package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned INST_SHIFT = $clog2(INST_BYTES);
  localparam int unsigned MAX_PC_W   = 64;

  typedef logic [MAX_PC_W-1:0] pc_max_t;

  typedef struct packed {
    logic    valid;
    pc_max_t tag;
    pc_max_t target;
  } btb_entry_t;

  // Word index of a PC, masked down to idx_w bits.
  function automatic pc_max_t btb_index(input pc_max_t pc, input int unsigned idx_w);
    pc_max_t mask;
    mask = (pc_max_t'(1) << idx_w) - pc_max_t'(1);
    return (pc >> INST_SHIFT) & mask;
  endfunction

  // Everything above the index field.
  function automatic pc_max_t btb_tag(input pc_max_t pc, input int unsigned idx_w);
    return pc >> (idx_w + INST_SHIFT);
  endfunction

endpackage

// File: rtl/btb_direct_mapped.sv
// rtl/btb_direct_mapped.sv - direct-mapped branch target buffer storage
//
// Purpose: BTB_ENTRIES x {valid, tag, target}; valid bits reset asynchronously,
// tag/target arrays are unreset data.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rd_idx_i            combinational read index
//   rd_entry_o          entry at rd_idx_i (tag/target zero-extended)
//   wr_en_i, wr_idx_i   write an entry valid with wr_tag_i / wr_target_i
//   inv_en_i, inv_idx_i clear the valid bit of one entry
// Reads see contents before any write in the same cycle.

module btb_direct_mapped
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BTB_ENTRIES = 64,
  localparam int unsigned IDX_W      = $clog2(BTB_ENTRIES),
  localparam int unsigned TAG_W      = PC_WIDTH - IDX_W - INST_SHIFT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output btb_entry_t          rd_entry_o,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [PC_WIDTH-1:0] wr_target_i,
  input  logic                inv_en_i,
  input  logic [IDX_W-1:0]    inv_idx_i
);

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    target_d [BTB_ENTRIES];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    // The two requests come from mutually exclusive EX cases; write wins anyway.
    if (wr_en_i) begin
      valid_d[wr_idx_i]  = 1'b1;
      tag_d[wr_idx_i]    = wr_tag_i;
      target_d[wr_idx_i] = wr_target_i;
    end else if (inv_en_i) begin
      valid_d[inv_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  always_comb begin
    rd_entry_o        = '0;
    rd_entry_o.valid  = valid_q[rd_idx_i];
    rd_entry_o.tag    = pc_max_t'(tag_q[rd_idx_i]);
    rd_entry_o.target = pc_max_t'(target_q[rd_idx_i]);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register, BTB steering and EX mispredict redirect
//
// Purpose: holds the fetch PC, looks it up in a direct-mapped BTB, combines a
// hit with the 2-bit predictor direction, redirects on EX mispredicts, drives
// the predictor update and trains the BTB.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   stall_i                         hold fetch PC
//   predict_taken_i                 predictor direction for pc_o
//   pc_o, btb_hit_o                 fetch PC and its BTB hit
//   pred_taken_o, pred_target_o     fetch prediction carried down the pipe
//   ex_*_i                          branch resolution from EX
//   flush_o                         squash IF/ID and ID/EX
//   bp_update_en_o, bp_actual_taken_o  predictor training
//   stat_branches_o, stat_mispredicts_o  saturating counters (FETCH_PC_STATS_EN only)
// Optional build macro: FETCH_PC_STATS_EN.

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          BTB_ENTRIES = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                predict_taken_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                pred_taken_o,
  output logic [PC_WIDTH-1:0] pred_target_o,
  output logic                btb_hit_o,
  input  logic                ex_valid_i,
  input  logic                ex_is_branch_i,
  input  logic [PC_WIDTH-1:0] ex_pc_i,
  input  logic                ex_actual_taken_i,
  input  logic [PC_WIDTH-1:0] ex_target_i,
  input  logic                ex_pred_taken_i,
  input  logic [PC_WIDTH-1:0] ex_pred_target_i,
  output logic                flush_o,
  output logic                bp_update_en_o,
  output logic                bp_actual_taken_o
`ifdef FETCH_PC_STATS_EN
  ,
  output logic [31:0]         stat_branches_o,
  output logic [31:0]         stat_mispredicts_o
`endif
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = PC_WIDTH - IDX_W - INST_SHIFT;
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INST_BYTES);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Lookup side
  pc_max_t     lk_idx_full, lk_tag_full;
  btb_entry_t  rd_entry;
  logic        hit;
  logic [PC_WIDTH-1:0] pc_plus4;

  // EX side
  pc_max_t     ex_idx_full, ex_tag_full;
  logic        dir_wrong, tgt_wrong, alias_hit, mispredict;
  logic [PC_WIDTH-1:0] correct_pc, next_pc;
  logic        btb_wr_en, btb_inv_en;

  assign lk_idx_full = btb_index(pc_max_t'(pc_q), IDX_W);
  assign lk_tag_full = btb_tag(pc_max_t'(pc_q), IDX_W);
  assign ex_idx_full = btb_index(pc_max_t'(ex_pc_i), IDX_W);
  assign ex_tag_full = btb_tag(pc_max_t'(ex_pc_i), IDX_W);

  btb_direct_mapped #(
    .PC_WIDTH    (PC_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (lk_idx_full[IDX_W-1:0]),
    .rd_entry_o  (rd_entry),
    .wr_en_i     (btb_wr_en),
    .wr_idx_i    (ex_idx_full[IDX_W-1:0]),
    .wr_tag_i    (ex_tag_full[TAG_W-1:0]),
    .wr_target_i (ex_target_i),
    .inv_en_i    (btb_inv_en),
    .inv_idx_i   (ex_idx_full[IDX_W-1:0])
  );

  // Stored tags are zero-extended, so a full-width compare is exact.
  assign hit       = rd_entry.valid && (rd_entry.tag == lk_tag_full);
  assign pc_plus4  = pc_q + STEP;

  assign pc_o          = pc_q;
  assign btb_hit_o     = hit;
  assign pred_taken_o  = hit && predict_taken_i;
  assign pred_target_o = hit ? rd_entry.target[PC_WIDTH-1:0] : pc_plus4;

  // EX resolution is ignored while reset is held so nothing leaks out or
  // trains the BTB during an asynchronous reset.
  always_comb begin
    dir_wrong  = ex_is_branch_i && (ex_actual_taken_i != ex_pred_taken_i);
    tgt_wrong  = ex_is_branch_i && ex_actual_taken_i && ex_pred_taken_i &&
                 (ex_pred_target_i != ex_target_i);
    alias_hit  = !ex_is_branch_i && ex_pred_taken_i;
    mispredict = !reset && ex_valid_i && (dir_wrong || tgt_wrong || alias_hit);
    correct_pc = (ex_actual_taken_i && ex_is_branch_i) ? ex_target_i : (ex_pc_i + STEP);
    btb_wr_en  = !reset && ex_valid_i && ex_is_branch_i && ex_actual_taken_i;
    btb_inv_en = !reset && ex_valid_i && alias_hit;
  end

  assign flush_o           = mispredict;
  assign bp_update_en_o    = !reset && ex_valid_i && ex_is_branch_i;
  assign bp_actual_taken_o = ex_actual_taken_i;

  always_comb begin
    next_pc = pc_plus4;
    if (mispredict) begin
      next_pc = correct_pc;
    end else if (stall_i) begin
      next_pc = pc_q;
    end else if (pred_taken_o) begin
      next_pc = pred_target_o;
    end
    pc_d = {next_pc[PC_WIDTH-1:INST_SHIFT], {INST_SHIFT{1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_PC_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bp_update_en_o && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (flush_o && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

  // Upper bits of the shared-width helpers and entry target are not needed here.
  logic unused_bits;
  assign unused_bits = ^{lk_idx_full, ex_idx_full, ex_tag_full, rd_entry.target};

endmodule
